// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher with a 2-entry first-word-fall-through queue and branch redirect.
// Define IFU_STALL_COUNT_EN to add a saturating stall_count output.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'd0,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_instruction,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc
`ifdef IFU_STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);
  localparam logic [15:0] LAST_PC = 16'(MEM_WORDS - 1);
  localparam logic [15:0] DEPTH   = 16'(MEM_WORDS);

  typedef enum logic [1:0] {RUN, FULL, REDIRECT} state_t;
  state_t state_reg;

  logic [15:0] pc_reg;
  logic [15:0] inflight_pc_reg;
  logic        inflight_reg;
  logic [15:0] q_data_reg [2];
  logic [15:0] q_pc_reg [2];
  logic        head_reg;
  logic [1:0]  count_reg;

  logic        pop;
  logic        issue;
  logic        tail;
  logic [1:0]  occupancy;

  assign mem_addr    = pc_reg;
  assign instr_valid = (count_reg != 2'd0);
  assign instr       = instr_valid ? q_data_reg[head_reg] : 16'd0;
  assign instr_pc    = instr_valid ? q_pc_reg[head_reg] : 16'd0;

  assign pop       = instr_valid && instr_ready;
  // Queue depth after this edge's push/pop; a new fetch needs it below 2 so its word has a slot.
  assign occupancy = count_reg + {1'b0, inflight_reg} - {1'b0, pop};
  assign issue     = !branch_valid && (occupancy < 2'd2);
  assign tail      = head_reg ^ count_reg[0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 16'd0;
      head_reg        <= 1'b0;
      count_reg       <= 2'd0;
      state_reg       <= RUN;
      for (int i = 0; i < 2; i++) begin
        q_data_reg[i] <= 16'd0;
        q_pc_reg[i]   <= 16'd0;
      end
    end else if (branch_valid) begin
      pc_reg       <= branch_target % DEPTH;
      inflight_reg <= 1'b0;
      head_reg     <= 1'b0;
      count_reg    <= 2'd0;
      state_reg    <= REDIRECT;
    end else begin
      if (inflight_reg) begin
        q_data_reg[tail] <= mem_instruction;
        q_pc_reg[tail]   <= inflight_pc_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      count_reg    <= occupancy;
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= pc_reg;
        pc_reg          <= (pc_reg == LAST_PC) ? 16'd0 : pc_reg + 16'd1;
      end
      case (state_reg)
        RUN:     if ((occupancy + {1'b0, issue}) == 2'd2) state_reg <= FULL;
        FULL:    if (pop) state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef IFU_STALL_COUNT_EN
  logic [15:0] stall_count_reg;
  assign stall_count = stall_count_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_count_reg <= 16'd0;
    end else if (instr_valid && !instr_ready && stall_count_reg != 16'hFFFF) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory model returns mem[i]=i one cycle after the address.
module tb_instruction_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] mem_addr;
  logic [15:0] mem_instruction;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
`ifdef IFU_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  logic [15:0] mem [256];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  always @(posedge clock) mem_instruction <= mem[mem_addr[7:0]];

  instruction_fetch_unit #(.RESET_PC(16'd0), .MEM_WORDS(256)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .mem_addr        (mem_addr),
    .mem_instruction (mem_instruction),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
`ifdef IFU_STALL_COUNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  task automatic step();
    @(negedge clock);
  endtask

  task automatic hold_reset(input logic ready);
    reset_n      = 1'b0;
    branch_valid = 1'b0;
    instr_ready  = ready;
    step();
    step();
  endtask

  task automatic test_reset();
    hold_reset(1'b1);
    step();
    tests_run++;
    if (instr_valid !== 1'b0 || instr !== 16'd0 || instr_pc !== 16'd0 || mem_addr !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b instr=%0d pc=%0d addr=%0d, required 0 0 0 0",
               instr_valid, instr, instr_pc, mem_addr);
    end
    $display("[TB] reset valid=%b addr=%0d", instr_valid, mem_addr);
  endtask

  task automatic test_sequential();
    reset_n = 1'b1;
    step();
    tests_run++;
    if (instr_valid !== 1'b0 || mem_addr !== 16'd1) begin
      tests_failed++;
      $display("FAIL seq_latency: valid=%b addr=%0d, required valid=0 addr=1", instr_valid, mem_addr);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== 16'(i) || instr_pc !== 16'(i)) begin
        tests_failed++;
        $display("FAIL seq_word%0d: valid=%b instr=%0d pc=%0d, required valid=1 instr=%0d pc=%0d",
                 i, instr_valid, instr, instr_pc, i, i);
      end
      $display("[TB] seq instr=%0d pc=%0d", instr, instr_pc);
      step();
    end
  endtask

  task automatic test_backpressure();
    hold_reset(1'b0);
    reset_n = 1'b1;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== 16'd0 || instr_pc !== 16'd0 || mem_addr !== 16'd2) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: valid=%b instr=%0d pc=%0d addr=%0d, required 1 0 0 2",
                 i, instr_valid, instr, instr_pc, mem_addr);
      end
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== 16'(i) || instr_pc !== 16'(i)) begin
        tests_failed++;
        $display("FAIL stall_release%0d: valid=%b instr=%0d pc=%0d, required valid=1 instr=%0d pc=%0d",
                 i, instr_valid, instr, instr_pc, i, i);
      end
      $display("[TB] release instr=%0d pc=%0d", instr, instr_pc);
      step();
    end
  endtask

  task automatic test_branch();
    bit found = 1'b0;
    hold_reset(1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid === 1'b1 && instr === 16'd5) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL branch_wait5: instr=%0d, required 5 within 20 cycles", instr);
    end
    instr_ready = 1'b0;
    step();
    branch_valid  = 1'b1;
    branch_target = 16'd170;
    instr_ready   = 1'b1;
    step();
    branch_valid = 1'b0;
    tests_run++;
    if (instr_valid !== 1'b0 || mem_addr !== 16'd170) begin
      tests_failed++;
      $display("FAIL branch_flush: valid=%b addr=%0d, required valid=0 addr=170", instr_valid, mem_addr);
    end
    step();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_bubble: valid=%b, required 0", instr_valid);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== 16'(170 + i) || instr_pc !== 16'(170 + i)) begin
        tests_failed++;
        $display("FAIL branch_word%0d: valid=%b instr=%0d pc=%0d, required valid=1 instr=%0d pc=%0d",
                 i, instr_valid, instr, instr_pc, 170 + i, 170 + i);
      end
      $display("[TB] branch instr=%0d pc=%0d", instr, instr_pc);
      step();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] expected [4];
    expected = '{16'd254, 16'd255, 16'd0, 16'd1};
    branch_valid  = 1'b1;
    branch_target = 16'd254;
    step();
    branch_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== expected[i] || instr_pc !== expected[i]) begin
        tests_failed++;
        $display("FAIL wrap_word%0d: valid=%b instr=%0d pc=%0d, required valid=1 instr=%0d pc=%0d",
                 i, instr_valid, instr, instr_pc, expected[i], expected[i]);
      end
      $display("[TB] wrap instr=%0d pc=%0d", instr, instr_pc);
      step();
    end
    branch_valid  = 1'b1;
    branch_target = 16'd300;
    step();
    branch_valid = 1'b0;
    tests_run++;
    if (mem_addr !== 16'd44) begin
      tests_failed++;
      $display("FAIL branch_mod: addr=%0d, required 44", mem_addr);
    end
    step();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    reset_n     = 1'b0;
    step();
    tests_run++;
    if (instr_valid !== 1'b0 || instr !== 16'd0 || mem_addr !== 16'd0) begin
      tests_failed++;
      $display("FAIL midreset_flush: valid=%b instr=%0d addr=%0d, required 0 0 0", instr_valid, instr, mem_addr);
    end
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    step();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_latency: valid=%b, required 0", instr_valid);
    end
    step();
    tests_run++;
    if (instr_valid !== 1'b1 || instr !== 16'd0 || instr_pc !== 16'd0) begin
      tests_failed++;
      $display("FAIL midreset_restart: valid=%b instr=%0d pc=%0d, required 1 0 0", instr_valid, instr, instr_pc);
    end
    $display("[TB] midreset instr=%0d pc=%0d", instr, instr_pc);
  endtask

`ifdef IFU_STALL_COUNT_EN
  task automatic test_stall_count();
    hold_reset(1'b0);
    tests_run++;
    if (stall_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL stall_count_reset: got %0d, required 0", stall_count);
    end
    reset_n = 1'b1;
    step();
    step();
    repeat (7) step();
    tests_run++;
    if (stall_count !== 16'd7) begin
      tests_failed++;
      $display("FAIL stall_count7: got %0d, required 7", stall_count);
    end
    instr_ready = 1'b1;
    step();
    tests_run++;
    if (stall_count !== 16'd7) begin
      tests_failed++;
      $display("FAIL stall_count_hold: got %0d, required 7", stall_count);
    end
    $display("[TB] stall_count=%0d", stall_count);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    reset_n       = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 16'd0;
    instr_ready   = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_wrap();
    test_reset_mid();
`ifdef IFU_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'd0: first fetch address after reset.
REQ-002 Parameter MEM_WORDS, default 256: instruction memory depth in words; PC wraps modulo MEM_WORDS.
REQ-003 clock  input  1  single clock; all state SHALL update on posedge clock only.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-005 mem_addr  output  16  address to the instruction memory; the memory samples it on posedge clock.
REQ-006 mem_instruction  input  16  memory read data for the address sampled at the previous posedge.
REQ-007 branch_valid  input  1  redirect request, one-cycle pulse.
REQ-008 branch_target  input  16  redirect address, qualified by branch_valid.
REQ-009 instr_valid  output  1  instr/instr_pc hold a valid fetched word.
REQ-010 instr_ready  input  1  decode accepts the word; transfer occurs when instr_valid and instr_ready are both high at a posedge.
REQ-011 instr  output  16  head-of-queue instruction word.
REQ-012 instr_pc  output  16  address of instr.

Function
REQ-013 The block SHALL keep a fetch PC register and drive mem_addr combinationally from it.
REQ-014 A fetch SHALL issue at a posedge when not in reset, branch_valid is low, and (queue_count + inflight - pop) < 2; on issue, inflight<=1, inflight_pc<=pc, pc<=(pc+1) mod MEM_WORDS.
REQ-015 When inflight is set, the following posedge SHALL write {mem_instruction, inflight_pc} into a 2-entry FIFO and clear inflight unless a new fetch issues that edge.
REQ-016 Fetch latency SHALL be 2 cycles: address issued at edge N, instr_valid high after edge N+1 if the queue was empty.
REQ-017 The FIFO SHALL be first-word-fall-through: instr/instr_pc/instr_valid reflect the head entry; pop and push in the same cycle are both honoured.
REQ-018 With 2 entries held and instr_ready low, no fetch SHALL issue, pc SHALL hold, and instr/instr_pc SHALL remain stable.
REQ-019 A fetch in flight SHALL never be dropped for lack of space; the issue rule in REQ-014 guarantees a free slot.
REQ-020 branch_valid at a posedge SHALL flush the FIFO, discard any in-flight word, and set pc<=branch_target mod MEM_WORDS; no fetch issues that edge; the target fetch issues the next edge.
REQ-021 branch_valid SHALL take priority over a simultaneous pop; instr_valid SHALL be low the cycle after a branch.
REQ-022 The PC at MEM_WORDS-1 SHALL wrap to 0 on the next sequential fetch.
REQ-023 FSM states SHALL be: RUN (issuing), FULL (queue plus in-flight at capacity), REDIRECT (one cycle after branch). RUN->FULL when capacity is reached; FULL->RUN on pop; any state->REDIRECT on branch_valid; REDIRECT->RUN next cycle.

Reset
REQ-024 While reset_n is low at a posedge: pc<=RESET_PC, FIFO empty, inflight<=0, state<=RUN, instr_valid=0, instr=0, instr_pc=0, stall_count=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued and in-flight words at that edge; the first fetch SHALL issue at the first posedge with reset_n high.

Configuration
REQ-026 With macro IFU_STALL_COUNT_EN defined, output stall_count[15:0] SHALL increment (saturating at 16'hFFFF) every cycle instr_valid is high and instr_ready is low; it is cleared by reset.
REQ-027 With IFU_STALL_COUNT_EN undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (memory preloaded with mem[i]=i)
REQ-028 Release reset, instr_ready=1 -> instr_valid rises 2 cycles later with instr=0, instr_pc=0, then 1, 2, 3 on consecutive cycles.
REQ-029 Hold instr_ready=0 for 10 cycles after the first word -> queue holds 0 and 1, mem_addr stuck at 2, instr=0 stable; after release, 0, 1, 2 delivered in order with no gap or duplicate.
REQ-030 branch_valid with target 170 while the queue holds 5, 6 -> instr_valid low the next cycle; next delivered instr=170, instr_pc=170, then 171.
REQ-031 Branch to 254 -> sequence 254, 255, 0, 1 (wrap at MEM_WORDS=256).
REQ-032 Reset asserted while 2 entries are queued and one is in flight -> instr_valid=0 the next cycle; after release, delivery restarts at RESET_PC.
REQ-033 With IFU_STALL_COUNT_EN defined, 7 stalled cycles with valid data -> stall_count=7; build without the macro compiles without the port.
